// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer.
//   alu_op_e    : 2-bit op code applied bitwise by the 1-bit slice.
//   alu_state_e : sequencer FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_XOR = 2'b00,
    ALU_NOR = 2'b01,
    ALU_OR  = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// Purely combinational 1-bit ALU slice.
//   a_i, b_i : operand bits
//   op_i     : operation (alu_op_e)
//   res_o    : result bit
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a_i,
  input  logic    b_i,
  input  alu_op_e op_i,
  output logic    res_o
);

  always_comb begin
    res_o = 1'b0;
    case (op_i)
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOR: res_o = ~(a_i | b_i);
      ALU_OR:  res_o = a_i | b_i;
      ALU_AND: res_o = a_i & b_i;
      default: res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer. Latches a WIDTH-bit operand pair and op on a
// valid/ready request, streams the operands LSB-first through one 1-bit
// slice (one bit per cycle) and returns the reassembled result plus a zero
// flag on a valid/ready response channel.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_valid / o_ready   : request handshake (o_ready high only in IDLE)
//   i_a, i_b, i_control : operands and op, sampled at the request handshake
//   o_valid / i_ready   : response handshake (o_valid high in DONE)
//   o_res, o_zero       : result and result==0 flag (zero only valid in DONE)
//   o_busy              : high in RUN or DONE
module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_control,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_zero,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  alu_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             zero_q;
  logic             busy_q;
  logic             slice_res;

  alu_bit_slice u_slice (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .op_i  (op_q),
    .res_o (slice_res)
  );

  // New result bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
  assign res_d = {slice_res, res_q[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= ALU_XOR;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ready_q) begin
            a_q     <= i_a;
            b_q     <= i_b;
            op_q    <= alu_op_e'(i_control);
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            // Flag from the completed value so it is ready with o_valid.
            zero_q  <= (res_d == '0);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          zero_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_res   = res_q;
  assign o_zero  = zero_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq (WIDTH=8), with a word-level
// reference model of the ALU ops and of the handshake timing.
module tb_alu_bitserial_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   ctl;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_res;
  logic         o_zero;
  logic         o_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (a),
    .i_b       (b),
    .i_control (ctl),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_res     (o_res),
    .o_zero    (o_zero),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return x ^ y;
      2'b01:   return ~(x | y);
      2'b10:   return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one request from IDLE and wait (bounded) for o_valid.
  // lat = edges after the handshake edge until o_valid is seen.
  task automatic do_request(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic [1:0] op, input bit perturb,
                            output int lat, output logic busy_after,
                            output logic ready_after);
    a = xa; b = xb; ctl = op; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    busy_after = o_busy;
    ready_after = o_ready;
    lat = 0;
    while (!o_valid && lat < 100) begin
      if (perturb) begin
        a = W'($urandom); b = W'($urandom); ctl = 2'($urandom);
      end
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; a = '0; b = '0; ctl = '0;
    repeat (3) tick;
    checks++;
    if ({o_ready, o_valid, o_res, o_zero, o_busy} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b res=%h zero=%b busy=%b, want 1 0 00 0 0",
               o_ready, o_valid, o_res, o_zero, o_busy);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b, want 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_ops;
    logic [W-1:0] va[4] = '{8'hA5, 8'hF0, 8'h12, 8'hFF};
    logic [W-1:0] vb[4] = '{8'h3C, 8'h0F, 8'h40, 8'h5A};
    logic [1:0]   vo[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [W-1:0] xa, xb, exp;
    logic [1:0]   op;
    int lat;
    logic bsy, rdy;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        xa = va[i]; xb = vb[i]; op = vo[i];
      end else begin
        xa = W'($urandom); xb = W'($urandom); op = 2'($urandom_range(0, 3));
      end
      exp = model(xa, xb, op);
      do_request(xa, xb, op, 1'b0, lat, bsy, rdy);
      checks++;
      if (bsy !== 1'b1 || rdy !== 1'b0) begin
        errors++;
        $display("FAIL ops_busy[%0d]: got busy=%b rdy=%b, want 1 0", i, bsy, rdy);
      end
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL ops_latency[%0d]: got %0d, want %0d", i, lat, W);
      end
      checks++;
      if (o_res !== exp || o_zero !== (exp == '0)) begin
        errors++;
        $display("FAIL ops_result[%0d]: got res=%h zero=%b, want res=%h zero=%b",
                 i, o_res, o_zero, exp, (exp == '0));
      end
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_zero !== 1'b0 || o_res !== exp) begin
        errors++;
        $display("FAIL ops_return_idle[%0d]: got rdy=%b vld=%b zero=%b res=%h, want 1 0 0 %h",
                 i, o_ready, o_valid, o_zero, o_res, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp;
    int lat;
    logic bsy, rdy;
    exp = model(8'hC3, 8'h96, 2'b10);
    do_request(8'hC3, 8'h96, 2'b10, 1'b0, lat, bsy, rdy);
    i_ready = 1'b0;
    a = 8'h01; b = 8'h02; ctl = 2'b11; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if (o_valid !== 1'b1 || o_res !== exp || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b res=%h rdy=%b busy=%b, want 1 %h 0 1",
                 k, o_valid, o_res, o_ready, o_busy, exp);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want 1 0", o_ready, o_valid);
    end
    tick;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_not_consumed: got busy=%b rdy=%b, want 0 1", o_busy, o_ready);
    end
  endtask

  task automatic test_perturb;
    logic [W-1:0] xa, xb, exp;
    logic [1:0] op;
    int lat;
    logic bsy, rdy;
    for (int i = 0; i < 4; i++) begin
      xa = W'($urandom); xb = W'($urandom); op = 2'($urandom_range(0, 3));
      exp = model(xa, xb, op);
      do_request(xa, xb, op, 1'b1, lat, bsy, rdy);
      checks++;
      if (lat !== W || o_res !== exp) begin
        errors++;
        $display("FAIL perturb[%0d]: got lat=%0d res=%h, want lat=%0d res=%h",
                 i, lat, o_res, W, exp);
      end
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic bsy, rdy;
    logic seen_valid;
    a = 8'h77; b = 8'h11; ctl = 2'b00; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_res, o_zero, o_busy} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async: got rdy=%b vld=%b res=%h zero=%b busy=%b, want 1 0 00 0 0",
               o_ready, o_valid, o_res, o_zero, o_busy);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      if (k == 2) rst_n = 1'b1;
      tick;
      if (o_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_valid: got seen_valid=%b busy=%b, want 0 0", seen_valid, o_busy);
    end
    do_request(8'h0F, 8'h3C, 2'b11, 1'b0, lat, bsy, rdy);
    checks++;
    if (lat !== W || o_res !== 8'h0C || o_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_fresh: got lat=%0d res=%h zero=%b, want %0d 0c 0",
               lat, o_res, o_zero, W);
    end
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] expq[$];
    int acc_cyc[$];
    int nacc, nresp, n;
    logic acc, resp;
    logic [W-1:0] exp;
    nacc = 0; nresp = 0; n = 0;
    i_ready = 1'b1;
    a = W'($urandom); b = W'($urandom); ctl = 2'($urandom);
    i_valid = 1'b1;
    while (nresp < 4 && n < 200) begin
      acc = o_ready && i_valid;
      resp = o_valid && i_ready;
      if (resp) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: got response res=%h, want none", o_res);
        end else begin
          exp = expq.pop_front();
          if (o_res !== exp) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h, want %h", nresp, o_res, exp);
          end
        end
        nresp++;
      end
      tick;
      n++;
      if (acc) begin
        expq.push_back(model(a, b, ctl));
        acc_cyc.push_back(cyc);
        nacc++;
        if (nacc < 4) begin
          a = W'($urandom); b = W'($urandom); ctl = 2'($urandom);
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (nresp !== 4 || nacc !== 4) begin
      errors++;
      $display("FAIL b2b_count: got acc=%0d resp=%0d, want 4 4", nacc, nresp);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== W + 2) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d, want %0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_backpressure;
    test_perturb;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
